// File: rtl/csr_gpio_if.sv
// CSR/GPIO request-response bundle between the control unit and the io responder.
// Latency: none of its own; the responder drives csr_rdata combinationally.
// Backpressure: none; the responder accepts every strobe in the cycle it is presented.
interface csr_gpio_if;
    logic        gpio_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    modport master (
        output gpio_we,
        output csr_addr,
        output csr_wdata,
        input  csr_rdata
    );

    modport slave (
        input  gpio_we,
        input  csr_addr,
        input  csr_wdata,
        output csr_rdata
    );
endinterface

// File: rtl/csr_gpio_io.sv
// CSR io responder: debounced switch input (SW_ADDR) and HEX display register (HEX_ADDR).
// Latency: reads are combinational; writes land at the strobe edge; switches settle after DEBOUNCE_CYCLES+3 edges.
// Backpressure: none; every write is taken at once. Optional SEG7_DECODE_EN adds a registered 7-segment output.
module csr_gpio_io #(
    parameter int          SW_WIDTH        = 18,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [11:0] SW_ADDR         = 12'hF00,
    parameter logic [11:0] HEX_ADDR        = 12'hF02
) (
    input  logic                clk,
    input  logic                rst_n,
    csr_gpio_if.slave           bus,
    input  logic [SW_WIDTH-1:0] sw_in,
    output logic                sw_change,
    output logic [31:0]         hex_out
`ifdef SEG7_DECODE_EN
    ,
    output logic [55:0]         hex_seg
`endif
);

    // Counter sized so DEBOUNCE_CYCLES-1 is representable and it never wraps.
    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] sync1_q, sync2_q;
    logic [SW_WIDTH-1:0] cand_q, cand_d;
    logic [SW_WIDTH-1:0] stable_q, stable_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sw_change_q, sw_change_d;
    logic [31:0]         hex_q, hex_d;
    logic [31:0]         rdata;

    // Debounce next state: any difference restarts the count; whole vector updates at once.
    always_comb begin
        cand_d      = cand_q;
        stable_d    = stable_q;
        cnt_d       = cnt_q;
        sw_change_d = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX && cand_q != stable_q) begin
            stable_d    = cand_q;
            sw_change_d = 1'b1;
            cnt_d       = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // HEX register next state: only a strobe aimed at HEX_ADDR writes it.
    always_comb begin
        hex_d = hex_q;
        if (bus.gpio_we && bus.csr_addr == HEX_ADDR) begin
            hex_d = bus.csr_wdata;
        end
    end

    // Two-flop synchronizer, debounce state and HEX register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cand_q      <= '0;
            stable_q    <= '0;
            cnt_q       <= '0;
            sw_change_q <= 1'b0;
            hex_q       <= '0;
        end else begin
            sync1_q     <= sw_in;
            sync2_q     <= sync1_q;
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            sw_change_q <= sw_change_d;
            hex_q       <= hex_d;
        end
    end

    // Read mux straight off the registers, so a CSRRW sees the pre-write value.
    always_comb begin
        rdata = 32'h0;
        if (bus.csr_addr == SW_ADDR) begin
            rdata = 32'(stable_q);
        end else if (bus.csr_addr == HEX_ADDR) begin
            rdata = hex_q;
        end
    end

    assign bus.csr_rdata = rdata;
    assign sw_change     = sw_change_q;
    assign hex_out       = hex_q;

`ifdef SEG7_DECODE_EN
    logic [55:0] seg_q, seg_d;

    // Active-low segments gfedcba for one hex digit.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Decode all eight nibbles of the current HEX register.
    always_comb begin
        seg_d = '0;
        for (int i = 0; i < 8; i++) begin
            seg_d[i*7 +: 7] = seg7(hex_q[i*4 +: 4]);
        end
    end

    // Segment register trails hex_out by one edge; resets to "0" on every digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= {8{7'h40}};
        end else begin
            seg_q <= seg_d;
        end
    end

    assign hex_seg = seg_q;
`endif

endmodule
